// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter fed by the cmd_parser txd_start/txd_data/txd_busy handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txd_start,
    input  logic [7:0] txd_data,
    output logic       txd_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_txd;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_txd_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;
`endif

    // txd/busy/done are computed one cycle ahead so the registered outputs line up with the state.
    always_comb begin
        w_bit_end   = (r_baud == BAUD_LAST);
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_txd_nxt  = 1'b1;
                if (txd_start) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = txd_data;
                    w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^txd_data;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_txd_nxt   = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = 3'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign txd      = r_txd;
    assign txd_busy = r_busy;
    assign tx_done  = r_done;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Byte-to-serial UART transmitter on the reply path from cmd_parser to the host. Accepts bytes on the txd_start/txd_data/txd_busy handshake that cmd_parser drives. Emits 8N1 frames (8 data bits, no parity, STOP_BITS stop bits) on a single serial line. Sits between cmd_parser and the board TX pin, and pairs with the existing UART receive path feeding rxd_data/rxd_data_ready.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud, truncated); must be >= 2
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
txd_start  input  1  single-cycle request to send txd_data
txd_data  input  8  byte to transmit, valid while txd_start=1
txd_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame completes
txd  output  1  serial line, idle high

Behaviour:
- Reset (reset=0 at a clk edge): txd=1, txd_busy=0, tx_done=0, FSM=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned. txd is 1 on the cycle after the reset edge. No tx_done is generated.
- FSM states: IDLE, START, DATA, PARITY (only with the option), STOP.
- IDLE: txd=1, txd_busy=0. If txd_start=1, latch txd_data into the shift register and go to START. txd_busy=1 from the next cycle.
- Acceptance rule: txd_start is honoured only in IDLE. txd_start while txd_busy=1 is ignored and has no effect on the frame in progress.
- START: txd=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after acceptance. Then go to DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit; a 3-bit counter counts 0..7. After bit 7, go to STOP (or PARITY with the option).
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. Then go to IDLE. tx_done=1 for exactly one cycle, and txd_busy=0 in that same cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary. Width is clog2(CLKS_PER_BIT). No drift across a frame.
- Frame length (acceptance+1 through the last stop cycle): (10+STOP_BITS-1)*CLKS_PER_BIT cycles; 11+STOP_BITS-1 bit periods with parity.
- Back-to-back frames: a txd_start in the tx_done cycle (IDLE) is accepted. The next start bit begins the following cycle, giving zero idle gap beyond the stop bits.
- txd is driven from a register (glitch-free). txd_busy and tx_done are registered.
- txd_data is only sampled at acceptance. Later changes do not affect the frame.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. It sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 8E1/8E2.
- Not defined: no PARITY state, no parity logic, 8N1/8N2 frame.

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1; reset low 3 cycles then high; txd_start with 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. txd_busy high 40 cycles. tx_done one pulse on cycle 41 after acceptance.
2. Send 0xA3 with txd_start asserted again in the tx_done cycle carrying 0x0F -> two contiguous frames: start(0), 1,1,0,0,0,1,0,1, stop(1), then start(0), 1,1,1,1,0,0,0,0, stop(1). No extra idle high.
3. Send 0x00; pulse txd_start with 0xFF at cycle 10 of the frame -> 0xFF ignored. Frame shows 9 low bit periods then stop. Exactly one tx_done.
4. Send 0xC8; drive reset=0 at cycle 15 -> txd=1, txd_busy=0 next cycle. No tx_done. A subsequent send of 0x41 produces a clean frame.
5. STOP_BITS=2: send 0x81 -> stop high for 8 cycles. txd_busy high 44 cycles.
6. UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Each frame 44 cycles busy at CLKS_PER_BIT=4.
